// File: rtl/wb_stage_if.sv
// wb_stage_if: ALU/LSU result handshakes, issue/scoreboard lookups and the
// register-file write port of wb_stage. Bypass signals exist only with WB_BYPASS_EN.
interface wb_stage_if #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic              alu_we;
  logic [IDX_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic              lsu_we;
  logic [IDX_W-1:0]  lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              issue_en;
  logic [IDX_W-1:0]  issue_rd;
  logic              issue_ready;
  logic [IDX_W-1:0]  rs1_index;
  logic [IDX_W-1:0]  rs2_index;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;
`ifdef WB_BYPASS_EN
  logic              rs1_fwd;
  logic              rs2_fwd;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
`endif

  modport slave (
    input  alu_valid, alu_we, alu_rd, alu_data,
    input  lsu_valid, lsu_we, lsu_rd, lsu_data,
    input  issue_en, issue_rd, rs1_index, rs2_index,
    output alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
`ifdef WB_BYPASS_EN
    output rs1_fwd, rs2_fwd, fwd_data1, fwd_data2,
`endif
    output rd_en, rd_index, rd_data
  );

  modport master (
    output alu_valid, alu_we, alu_rd, alu_data,
    output lsu_valid, lsu_we, lsu_rd, lsu_data,
    output issue_en, issue_rd, rs1_index, rs2_index,
    input  alu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy,
`ifdef WB_BYPASS_EN
    input  rs1_fwd, rs2_fwd, fwd_data1, fwd_data2,
`endif
    input  rd_en, rd_index, rd_data
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: LSU-over-ALU writeback arbiter with a registered register-file write
// port and a 2-bit pending-write scoreboard per register. Optional bypass: WB_BYPASS_EN.
module wb_stage #(
  parameter int DATA_W  = 64,
  parameter int IDX_W   = 5,
  parameter int REG_NUM = 32
) (
  input  logic      clk,
  input  logic      rst,
  wb_stage_if.slave wb
);
  logic               rd_en_q, rd_en_d;
  logic [IDX_W-1:0]   rd_index_q, rd_index_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [1:0]         cnt_q [REG_NUM];
  logic [1:0]         cnt_d [REG_NUM];
  logic [REG_NUM-1:0] inc_vec;
  logic [REG_NUM-1:0] dec_vec;
  logic               issue_go;
  logic [1:0]         cnt_rs1, cnt_rs2;

  // A load result is always older than a concurrent ALU result, so LSU wins.
  assign wb.lsu_ready = 1'b1;
  assign wb.alu_ready = !wb.lsu_valid;

  always_comb begin
    rd_en_d    = 1'b0;
    rd_index_d = rd_index_q;
    rd_data_d  = rd_data_q;
    if (wb.lsu_valid) begin
      rd_en_d    = wb.lsu_we && (wb.lsu_rd != '0);
      rd_index_d = wb.lsu_rd;
      rd_data_d  = wb.lsu_data;
    end else if (wb.alu_valid) begin
      rd_en_d    = wb.alu_we && (wb.alu_rd != '0);
      rd_index_d = wb.alu_rd;
      rd_data_d  = wb.alu_data;
    end
  end

  assign wb.issue_ready = (wb.issue_rd == '0) || (cnt_q[wb.issue_rd] != 2'd3);
  assign issue_go       = wb.issue_en && wb.issue_ready;

  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign inc_vec[gi] = 1'b0;
        assign dec_vec[gi] = 1'b0;
      end else begin : g_xn
        assign inc_vec[gi] = issue_go && (wb.issue_rd == IDX_W'(gi));
        assign dec_vec[gi] = rd_en_q && (rd_index_q == IDX_W'(gi));
      end
    end
  endgenerate

  // Simultaneous issue and writeback of one register cancel out.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i])
        cnt_d[i] = cnt_q[i] + 2'd1;
      else if (dec_vec[i] && !inc_vec[i] && cnt_q[i] != 2'd0)
        cnt_d[i] = cnt_q[i] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q    <= 1'b0;
      rd_index_q <= '0;
      rd_data_q  <= '0;
      for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= 2'd0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_index_q <= rd_index_d;
      rd_data_q  <= rd_data_d;
      for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign wb.rd_en    = rd_en_q;
  assign wb.rd_index = rd_index_q;
  assign wb.rd_data  = rd_data_q;
  assign cnt_rs1     = cnt_q[wb.rs1_index];
  assign cnt_rs2     = cnt_q[wb.rs2_index];

`ifdef WB_BYPASS_EN
  // The last outstanding write is on the port now: hand it to decode directly.
  assign wb.rs1_fwd   = rd_en_q && (rd_index_q == wb.rs1_index) && (cnt_rs1 == 2'd1);
  assign wb.rs2_fwd   = rd_en_q && (rd_index_q == wb.rs2_index) && (cnt_rs2 == 2'd1);
  assign wb.fwd_data1 = rd_data_q;
  assign wb.fwd_data2 = rd_data_q;
  assign wb.rs1_busy  = (wb.rs1_index != '0) && (cnt_rs1 != 2'd0) && !wb.rs1_fwd;
  assign wb.rs2_busy  = (wb.rs2_index != '0) && (cnt_rs2 != 2'd0) && !wb.rs2_fwd;
`else
  assign wb.rs1_busy  = (wb.rs1_index != '0) && (cnt_rs1 != 2'd0);
  assign wb.rs2_busy  = (wb.rs2_index != '0) && (cnt_rs2 != 2'd0);
`endif

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    rd_en_q |-> (cnt_q[rd_index_q] != 2'd0));
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios plus protocol-legal random traffic, checked every
// cycle against a count-based model of pending writes and the writeback port.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(64), .IDX_W(5)) bus ();
  wb_stage #(.DATA_W(64), .IDX_W(5), .REG_NUM(32)) dut (.clk(clk), .rst(rst), .wb(bus));

  int checks = 0;
  int errors = 0;

  // Reference: pending writes per register and the value on the write port.
  int          m_cnt [32];
  logic        m_rd_en = 1'b0;
  logic [4:0]  m_rd_idx = '0;
  logic [63:0] m_rd_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] <= 0;
      m_rd_en <= 1'b0; m_rd_idx <= '0; m_rd_data <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        int n;
        n = m_cnt[i];
        if (i != 0 && bus.issue_en && int'(bus.issue_rd) == i && m_cnt[i] != 3) n = n + 1;
        if (m_rd_en && int'(m_rd_idx) == i) n = n - 1;
        m_cnt[i] <= (n < 0) ? 0 : n;
      end
      if (bus.lsu_valid) begin
        m_rd_en <= bus.lsu_we && bus.lsu_rd != 0; m_rd_idx <= bus.lsu_rd; m_rd_data <= bus.lsu_data;
      end else if (bus.alu_valid) begin
        m_rd_en <= bus.alu_we && bus.alu_rd != 0; m_rd_idx <= bus.alu_rd; m_rd_data <= bus.alu_data;
      end else begin
        m_rd_en <= 1'b0;
      end
    end
  end

  // Hand-computed expectations, queued by the stimulus and checked by the compare process.
  localparam int S_RD_EN = 0, S_RD_IDX = 1, S_RD_DATA = 2, S_BUSY1 = 3, S_BUSY2 = 4;
  localparam int S_IRDY = 5, S_ARDY = 6, S_FWD1 = 7, S_FWDD1 = 8;
  string       lit_name [128];
  int          lit_sel  [128];
  logic [63:0] lit_exp  [128];
  int          lit_n = 0;
  int          lit_done = 0;

  function automatic logic [63:0] dut_sig(input int sel);
    case (sel)
      S_RD_EN:   return 64'(bus.rd_en);
      S_RD_IDX:  return 64'(bus.rd_index);
      S_RD_DATA: return bus.rd_data;
      S_BUSY1:   return 64'(bus.rs1_busy);
      S_BUSY2:   return 64'(bus.rs2_busy);
      S_IRDY:    return 64'(bus.issue_ready);
      S_ARDY:    return 64'(bus.alu_ready);
`ifdef WB_BYPASS_EN
      S_FWD1:    return 64'(bus.rs1_fwd);
      S_FWDD1:   return bus.fwd_data1;
`endif
      default:   return '1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negative clock edge and immediately after reset assertion.
  always begin
    logic f1, f2;
    @(negedge clk or negedge rst);
    #1;
    f1 = m_rd_en && m_rd_idx == bus.rs1_index && m_cnt[bus.rs1_index] == 1;
    f2 = m_rd_en && m_rd_idx == bus.rs2_index && m_cnt[bus.rs2_index] == 1;
`ifndef WB_BYPASS_EN
    f1 = 1'b0; f2 = 1'b0;
`endif
    chk("alu_ready", 64'(bus.alu_ready), 64'(!bus.lsu_valid));
    chk("lsu_ready", 64'(bus.lsu_ready), 64'd1);
    chk("issue_ready", 64'(bus.issue_ready), 64'(bus.issue_rd == 0 || m_cnt[bus.issue_rd] != 3));
    chk("rs1_busy", 64'(bus.rs1_busy), 64'(bus.rs1_index != 0 && m_cnt[bus.rs1_index] != 0 && !f1));
    chk("rs2_busy", 64'(bus.rs2_busy), 64'(bus.rs2_index != 0 && m_cnt[bus.rs2_index] != 0 && !f2));
    chk("rd_en", 64'(bus.rd_en), 64'(m_rd_en));
    chk("rd_index", 64'(bus.rd_index), 64'(m_rd_idx));
    chk("rd_data", bus.rd_data, m_rd_data);
`ifdef WB_BYPASS_EN
    chk("rs1_fwd", 64'(bus.rs1_fwd), 64'(f1));
    chk("rs2_fwd", 64'(bus.rs2_fwd), 64'(f2));
    if (f1) chk("fwd_data1", bus.fwd_data1, m_rd_data);
    if (f2) chk("fwd_data2", bus.fwd_data2, m_rd_data);
`endif
    while (lit_done < lit_n) begin
      chk(lit_name[lit_done], dut_sig(lit_sel[lit_done]), lit_exp[lit_done]);
      lit_done++;
    end
  end

  task automatic lit(input string n, input int sel, input logic [63:0] e);
    lit_name[lit_n] = n; lit_sel[lit_n] = sel; lit_exp[lit_n] = e;
    lit_n++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_alu(input logic v, input logic we, input logic [4:0] rd, input logic [63:0] d);
    bus.alu_valid = v; bus.alu_we = we; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic we, input logic [4:0] rd, input logic [63:0] d);
    bus.lsu_valid = v; bus.lsu_we = we; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic set_issue(input logic en, input logic [4:0] rd);
    bus.issue_en = en; bus.issue_rd = rd;
  endtask

  // Writes issued but not yet handed to a beat; random beats only target these.
  int owed [32];

  task automatic pick_beat(input int pct, output logic v, output logic we,
                           output logic [4:0] rd, output logic [63:0] d);
    int k, st;
    bit found;
    v = ($urandom_range(0, 99) < pct);
    we = 1'b0; rd = 5'($urandom_range(0, 31)); d = {$urandom, $urandom};
    if (v) begin
      k = $urandom_range(0, 9);
      if (k < 7) begin
        st = $urandom_range(0, 30); found = 1'b0;
        for (int j = 0; j < 31; j++) begin
          int r;
          r = 1 + ((st + j) % 31);
          if (!found && owed[r] > 0) begin found = 1'b1; rd = 5'(r); end
        end
        if (found) begin we = 1'b1; owed[rd]--; end
      end else if (k == 7) begin
        we = 1'b1; rd = 5'd0;
      end
    end
  endtask

  initial begin
    logic v, we;
    logic [4:0] rd;
    logic [63:0] d;
    for (int i = 0; i < 32; i++) owed[i] = 0;
    set_alu(0, 0, 0, 0); set_lsu(0, 0, 0, 0); set_issue(0, 0);
    bus.rs1_index = 5'd5; bus.rs2_index = 5'd0;
    #2 rst = 1'b0;
    step();
    lit("reset_rd_en", S_RD_EN, 0); lit("reset_issue_ready", S_IRDY, 1); lit("reset_busy1", S_BUSY1, 0);
    step();
    rst = 1'b1;

    // Single ALU writeback to x5.
    set_issue(1, 5); lit("s1_busy_before", S_BUSY1, 0);
    step(); set_issue(0, 0); set_alu(1, 1, 5, 64'h1234); lit("s1_busy_pending", S_BUSY1, 1);
    step(); set_alu(0, 0, 0, 0);
    lit("s1_rd_en", S_RD_EN, 1); lit("s1_rd_index", S_RD_IDX, 5); lit("s1_rd_data", S_RD_DATA, 64'h1234);
`ifdef WB_BYPASS_EN
    lit("s1_fwd", S_FWD1, 1); lit("s1_fwd_data", S_FWDD1, 64'h1234); lit("s1_busy_fwd", S_BUSY1, 0);
`else
    lit("s1_busy_wb", S_BUSY1, 1);
`endif
    step(); lit("s1_rd_en_off", S_RD_EN, 0); lit("s1_busy_clear", S_BUSY1, 0);

    // Concurrent LSU and ALU beats.
    set_issue(1, 3);
    step(); set_issue(1, 4);
    step(); set_issue(0, 0); set_alu(1, 1, 3, 64'hA); set_lsu(1, 1, 4, 64'hB); lit("s2_alu_stall", S_ARDY, 0);
    step(); set_lsu(0, 0, 0, 0);
    lit("s2_lsu_idx", S_RD_IDX, 4); lit("s2_lsu_data", S_RD_DATA, 64'hB); lit("s2_alu_ready", S_ARDY, 1);
    step(); set_alu(0, 0, 0, 0);
    lit("s2_alu_en", S_RD_EN, 1); lit("s2_alu_idx", S_RD_IDX, 3); lit("s2_alu_data", S_RD_DATA, 64'hA);
    step(); lit("s2_idle", S_RD_EN, 0);

    // Write to x0 is dropped.
    set_alu(1, 1, 0, 64'hFFFF);
    step(); set_alu(0, 0, 0, 0);
    lit("s3_x0_en", S_RD_EN, 0); lit("s3_x0_idx", S_RD_IDX, 0); lit("s3_x0_data", S_RD_DATA, 64'hFFFF);

    // Saturate x7.
    set_issue(1, 7);
    step(); step();
    step(); set_issue(0, 7); lit("s4_x7_full", S_IRDY, 0);
    step(); set_issue(0, 8); set_alu(1, 1, 7, 64'h77); lit("s4_x8_ready", S_IRDY, 1);
    step(); set_alu(0, 0, 0, 0); set_issue(0, 7); lit("s4_x7_still_full", S_IRDY, 0);
    step(); lit("s4_x7_ready", S_IRDY, 1); set_alu(1, 1, 7, 64'h71);
    step(); set_alu(1, 1, 7, 64'h72);
    step(); set_alu(0, 0, 0, 0);
    step();

    // Issue and writeback of x9 in the same cycle.
    set_issue(1, 9); bus.rs2_index = 5'd9;
    step(); set_issue(0, 0); set_alu(1, 1, 9, 64'h99);
    step(); set_alu(0, 0, 0, 0); set_issue(1, 9);
`ifdef WB_BYPASS_EN
    lit("s5_busy_fwd", S_BUSY2, 0);
`else
    lit("s5_busy_wb", S_BUSY2, 1);
`endif
    step(); set_issue(0, 0); lit("s5_busy_after", S_BUSY2, 1); lit("s5_rd_en_off", S_RD_EN, 0);
    set_alu(1, 1, 9, 64'h98);
    step(); set_alu(0, 0, 0, 0);
    step();

    // Asynchronous reset with a captured beat and x2 pending twice.
    set_issue(1, 2); bus.rs1_index = 5'd2; bus.rs2_index = 5'd2;
    step();
    step(); set_issue(0, 2); set_alu(1, 1, 2, 64'h22);
    step(); set_alu(0, 0, 0, 0);
    lit("s6_rd_en_pre", S_RD_EN, 1); lit("s6_busy_pre", S_BUSY1, 1);
    @(negedge clk); #3;
    lit("s6_rd_en_async", S_RD_EN, 0); lit("s6_busy1_async", S_BUSY1, 0);
    lit("s6_busy2_async", S_BUSY2, 0); lit("s6_ready_async", S_IRDY, 1);
    rst = 1'b0;
    step(); step();
    rst = 1'b1;

    // Random protocol-legal traffic.
    for (int c = 0; c < 2500; c++) begin
      bus.rs1_index = 5'($urandom_range(0, 31));
      bus.rs2_index = 5'($urandom_range(0, 31));
      if (!(bus.alu_valid && bus.lsu_valid)) begin
        pick_beat(55, v, we, rd, d); set_alu(v, we, rd, d);
      end
      pick_beat(30, v, we, rd, d); set_lsu(v, we, rd, d);
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
      if ($urandom_range(0, 99) < 45 && (rd == 0 || m_cnt[rd] != 3)) begin
        set_issue(1, rd);
        if (rd != 0) owed[rd]++;
      end else begin
        set_issue(0, rd);
      end
      step();
    end
    set_alu(0, 0, 0, 0); set_lsu(0, 0, 0, 0); set_issue(0, 0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the in-order RV64 core. It merges results from the ALU path and the load/store path onto the single register file write port, and drives `rd_en`/`rd_index`/`rd_data` from registers. It also keeps a per-register scoreboard of in-flight writes that decode uses to stall on read-after-write hazards. It sits between execute/memory and the register file.

## Interface
Parameters:
- `DATA_W`, 64: register data width.
- `IDX_W`, 5: register index width.
- `REG_NUM`, 32: number of architectural registers; x0 is hardwired zero.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `alu_valid`  input  1  ALU result valid.
- `alu_ready`  output  1  ALU result accepted this cycle.
- `alu_we`  input  1  ALU result writes rd.
- `alu_rd`  input  IDX_W  ALU destination index.
- `alu_data`  input  DATA_W  ALU result.
- `lsu_valid`  input  1  load/store result valid.
- `lsu_ready`  output  1  load/store result accepted.
- `lsu_we`  input  1  load writes rd (0 for stores).
- `lsu_rd`  input  IDX_W  load destination index.
- `lsu_data`  input  DATA_W  load data.
- `issue_en`  input  1  decode issues an instruction that writes rd.
- `issue_rd`  input  IDX_W  destination of the issuing instruction.
- `issue_ready`  output  1  scoreboard can accept `issue_rd`.
- `rs1_index`, `rs2_index`  input  IDX_W  decode source indices.
- `rs1_busy`, `rs2_busy`  output  1  source has a pending write.
- `rd_en`  output  1  register file write enable.
- `rd_index`  output  IDX_W  register file write index.
- `rd_data`  output  DATA_W  register file write data.

## Operation
- Arbitration: LSU has fixed priority, because a load result is always older than a concurrent ALU result. `lsu_ready` = 1. `alu_ready` = !`lsu_valid`.
- Acceptance: an accepted beat (valid && ready) is captured into the output registers. `rd_en` <= we && (rd != 0). `rd_index` and `rd_data` are loaded from the same source. With no accepted beat, `rd_en` <= 0 and `rd_index`/`rd_data` hold their values.
- Scoreboard: each register x1..x31 has a 2-bit pending counter `cnt[i]`. x0 never counts.
  - Increment when `issue_en && issue_ready && issue_rd == i`.
  - Decrement when `rd_en && rd_index == i`, on the same edge the register file commits the write.
  - Increment and decrement of the same index in the same cycle leave `cnt` unchanged.
- `issue_ready` = (`issue_rd` == 0) || (`cnt[issue_rd]` != 3). Decode must not assert `issue_en` while `issue_ready` = 0.
- `rsN_busy` = (`rsN_index` != 0) && (`cnt[rsN_index]` != 0). This is combinational on the current counters.
- A beat with we=1 and rd=0, or with we=0, produces `rd_en` = 0 and no decrement. Decode never issues such beats to the scoreboard.
- A decrement while the counter is 0 is a protocol error. The counter stays at 0, and simulation builds flag it with an assertion.

## Timing
- Reset (asynchronous, `rst` low): `rd_en` = 0, `rd_index` = 0, `rd_data` = 0, all `cnt` = 0.
  - Outputs then read `alu_ready` = !`lsu_valid`, `lsu_ready` = 1, `issue_ready` = 1, `rsN_busy` = 0.
  - Assertion mid-operation discards any captured beat and all pending counts immediately.
- Latency: a beat accepted at edge N drives `rd_en` high for the cycle after N. The register file writes at edge N+1. `cnt` drops at edge N+1, so `rsN_busy` clears in the cycle after N+1.
- Throughput: one writeback per cycle. The ALU stalls only during cycles where `lsu_valid` = 1.
- Ready outputs are combinational on `lsu_valid` and `issue_rd` only. There is no path from `alu_valid` to `alu_ready`.

## Configuration
- `WB_BYPASS_EN` defined:
  - Adds outputs `rs1_fwd` and `rs2_fwd` (1 bit each), plus `fwd_data1` and `fwd_data2` (DATA_W each).
  - `rsN_fwd` = `rd_en` && (`rd_index` == `rsN_index`) && (`cnt[rsN_index]` == 1). In that case `fwd_dataN` = `rd_data`, and `rsN_busy` is forced to 0, so decode consumes the value in the writeback cycle.
- `WB_BYPASS_EN` undefined: these ports do not exist and `rsN_busy` behaves as described under Operation.

## Test plan
- Release reset, then issue rd=5 and drive an ALU beat with we=1, rd=5, data=0x1234 at edge N. Required: `rs1_busy` = 1 for `rs1_index`=5 until the cycle after N+1; `rd_en`=1, `rd_index`=5, `rd_data`=0x1234 in cycle N+1.
- Drive `alu_valid` and `lsu_valid` together (ALU rd=3 data=0xA, LSU rd=4 data=0xB). Required: `alu_ready`=0, the LSU beat is written first, and the ALU beat is written the following cycle with identical data.
- Beat with we=1, rd=0, data=0xFFFF. Required: `rd_en`=0 and all counters unchanged.
- Issue rd=7 three times without writeback. Required: `issue_ready`=0 for rd=7 and 1 for rd=8. One writeback to rd=7 restores `issue_ready`=1.
- In one cycle, issue rd=9 while writeback of rd=9 is active with `cnt`=1. Required: `cnt[9]` stays 1 and `rs2_busy` stays 1 for `rs2_index`=9.
- Assert `rst` low mid-stream with `rd_en`=1 and `cnt[2]`=2. Required: `rd_en` drops without waiting for a clock and all busy outputs read 0. With `WB_BYPASS_EN` defined, repeat the first scenario and require `rs1_fwd`=1 and `fwd_data1`=0x1234 in cycle N+1.
